lc3_intc: RTL and testbench



---
 rtl/lc3_intc.sv | 169 ++++++++++++++++
 tb/tb_lc3_intc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_intc.sv
// Multi-source interrupt controller for the LC3 core: synchronises NUM_CH sources,
// keeps per-channel enable/mode/priority, and presents one registered IRQ/INTV/INTP.
module lc3_intc #(
  parameter int               NUM_CH    = 8,
  parameter logic [7:0]       VEC_BASE  = 8'h80,
  parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b1}},
  parameter int               AW        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_src,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [15:0]       cfg_din,
  output logic [15:0]       cfg_dout,
  input  logic              irq_ack,
  output logic              IRQ,
  output logic [7:0]        INTV,
  output logic [2:0]        INTP
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync2_q, sdly_q;
  logic [NUM_CH-1:0] enable_q, enable_d, mode_q, mode_d, pend_q, pend_d;
  logic [2:0]        pri_q [NUM_CH];
  logic [2:0]        pri_d [NUM_CH];
  logic [IW-1:0]     cur_q, cur_d;
  logic              irq_q, irq_d;
  logic [7:0]        intv_q, intv_d;
  logic [2:0]        intp_q, intp_d;
  logic [NUM_CH-1:0] w1c, ackClr, elig;
  logic              anyElig, load;
  logic [IW-1:0]     win;
  logic [2:0]        winPri;
  logic              din_unused;

  assign din_unused = ^cfg_din[15:NUM_CH];

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    pri_d    = pri_q;
    w1c      = '0;
    if (cfg_we) begin
      if (cfg_addr == AW'(0)) enable_d = cfg_din[NUM_CH-1:0];
      if (cfg_addr == AW'(1)) mode_d   = cfg_din[NUM_CH-1:0];
      if (cfg_addr == AW'(2)) w1c      = cfg_din[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (cfg_addr == AW'(3 + i)) pri_d[i] = cfg_din[2:0];
    end
  end

  always_comb begin
    cfg_dout = '0;
    if (cfg_addr == AW'(0)) cfg_dout[NUM_CH-1:0] = enable_q;
    if (cfg_addr == AW'(1)) cfg_dout[NUM_CH-1:0] = mode_q;
    if (cfg_addr == AW'(2)) cfg_dout[NUM_CH-1:0] = pend_q;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_addr == AW'(3 + i)) cfg_dout[2:0] = pri_q[i];
  end

  // Strict '>' while scanning upward keeps the lowest index on priority ties.
  always_comb begin
    elig    = '0;
    anyElig = 1'b0;
    win     = '0;
    winPri  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = pend_q[i] & enable_q[i] & (pri_q[i] != 3'd0);
      if (elig[i] && (pri_q[i] > winPri)) begin
        anyElig = 1'b1;
        win     = IW'(i);
        winPri  = pri_q[i];
      end
    end
  end

  // Level channels load the synchroniser output so PENDING tracks s_d exactly.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      pend_d[i] = mode_q[i] ? ((sync2_q[i] & ~sdly_q[i]) | (pend_q[i] & ~w1c[i] & ~ackClr[i]))
                            : sync2_q[i];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    irq_d   = irq_q;
    intv_d  = intv_q;
    intp_d  = intp_q;
    ackClr  = '0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (anyElig) begin
          load    = 1'b1;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ackClr[cur_q] = 1'b1;
          irq_d         = 1'b0;
          state_d       = GAP;
        end else if (!elig[cur_q]) begin
          if (anyElig) begin
            load = 1'b1;
          end else begin
            irq_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (winPri > intp_q) begin
          load = 1'b1;
        end
      end
      GAP: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cur_d  = win;
      intv_d = VEC_BASE + 8'(win);
      intp_d = winPri;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sdly_q   <= '0;
      enable_q <= '0;
      mode_q   <= EDGE_MASK;
      pend_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) pri_q[i] <= '0;
      cur_q    <= '0;
      irq_q    <= 1'b0;
      intv_q   <= '0;
      intp_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= irq_src;
      sync2_q  <= sync1_q;
      sdly_q   <= sync2_q;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      pri_q    <= pri_d;
      cur_q    <= cur_d;
      irq_q    <= irq_d;
      intv_q   <= intv_d;
      intp_q   <= intp_d;
    end
  end

  assign IRQ  = irq_q;
  assign INTV = intv_q;
  assign INTP = intp_q;

endmodule

// File: tb/tb_lc3_intc.sv
// Directed and randomised checks of lc3_intc against a priority/pending model held in the bench.
module tb_lc3_intc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_din = '0;
  logic [15:0] cfg_dout;
  logic        irq_ack = 1'b0;
  logic        IRQ;
  logic [7:0]  INTV;
  logic [2:0]  INTP;

  int checks = 0;
  int passes = 0;

  int       modelPri [8];
  bit [7:0] modelEn;
  bit [7:0] modelPend;

  lc3_intc dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_din(cfg_din), .cfg_dout(cfg_dout), .irq_ack(irq_ack),
    .IRQ(IRQ), .INTV(INTV), .INTP(INTP)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkIrq(input string tag, input logic i, input logic [7:0] v, input logic [2:0] p);
    checkOutput({tag, "_irq"}, 16'(IRQ), 16'(i));
    checkOutput({tag, "_intv"}, 16'(INTV), 16'(v));
    checkOutput({tag, "_intp"}, 16'(INTP), 16'(p));
  endtask

  task automatic checkReg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    cfg_addr = a;
    #1;
    checkOutput(tag, cfg_dout, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] s);
    irq_src = s;
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
    tick(1);
    cfg_we = 1'b0; cfg_din = '0;
  endtask

  task automatic ackPulse();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  // Highest priority among pending, enabled, nonzero-priority channels; lowest index on ties.
  function automatic int pickWinner();
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (modelPend[i] && modelEn[i] && modelPri[i] > 0 && (best < 0 || modelPri[i] > modelPri[best]))
        best = i;
    return best;
  endfunction

  initial begin
    int dropped;
    int w;
    logic [7:0] src;

    tick(2);
    checkIrq("reset", 1'b0, 8'h00, 3'd0);
    checkReg("reset_mode", 4'd1, 16'h00FF);
    rst = 1'b0;
    tick(1);

    // Single edge channel
    writeReg(4'd0, 16'h0001);
    writeReg(4'd3, 16'h0003);
    applyStimulus(8'h01);
    tick(3);
    checkOutput("lat_edge3", 16'(IRQ), 16'd0);
    tick(1);
    checkIrq("lat_edge4", 1'b1, 8'h80, 3'd3);
    applyStimulus(8'h00);
    checkReg("pend_ch0", 4'd2, 16'h0001);
    tick(1);
    ackPulse();
    checkOutput("ack_drop", 16'(IRQ), 16'd0);
    checkReg("ack_clear", 4'd2, 16'h0000);
    tick(4);
    checkOutput("no_rereq", 16'(IRQ), 16'd0);

    // Priority and tie-break
    writeReg(4'd0, 16'h0026);
    writeReg(4'd5, 16'h0005);
    writeReg(4'd8, 16'h0005);
    writeReg(4'd4, 16'h0002);
    applyStimulus(8'h26);
    tick(4);
    checkIrq("tie_first", 1'b1, 8'h82, 3'd5);
    applyStimulus(8'h00);
    ackPulse();
    checkOutput("tie_ack", 16'(IRQ), 16'd0);
    tick(1);
    checkOutput("tie_gap", 16'(IRQ), 16'd0);
    tick(1);
    checkIrq("tie_second", 1'b1, 8'h85, 3'd5);
    ackPulse();
    tick(2);
    checkIrq("tie_third", 1'b1, 8'h81, 3'd2);

    // Preemption of ch1 by ch6
    writeReg(4'd0, 16'h0066);
    writeReg(4'd9, 16'h0007);
    applyStimulus(8'h40);
    tick(3);
    checkIrq("pre_before", 1'b1, 8'h81, 3'd2);
    tick(1);
    checkIrq("pre_after", 1'b1, 8'h86, 3'd7);
    applyStimulus(8'h00);
    ackPulse();
    checkOutput("pre_ack", 16'(IRQ), 16'd0);
    tick(2);
    checkIrq("pre_resume", 1'b1, 8'h81, 3'd2);
    ackPulse();
    tick(3);
    checkOutput("pre_done", 16'(IRQ), 16'd0);

    // Level mode on ch3
    writeReg(4'd1, 16'h00F7);
    writeReg(4'd6, 16'h0004);
    writeReg(4'd0, 16'h0008);
    applyStimulus(8'h08);
    tick(4);
    checkIrq("lvl_req", 1'b1, 8'h83, 3'd4);
    ackPulse();
    checkOutput("lvl_ack", 16'(IRQ), 16'd0);
    tick(1);
    checkOutput("lvl_gap", 16'(IRQ), 16'd0);
    tick(1);
    checkIrq("lvl_rereq", 1'b1, 8'h83, 3'd4);
    applyStimulus(8'h00);
    dropped = 0;
    for (int k = 0; k < 6 && dropped == 0; k++) begin
      tick(1);
      if (IRQ === 1'b0) dropped = 1;
    end
    checkOutput("lvl_drop_timeout", 16'(dropped), 16'd1);
    tick(3);
    checkOutput("lvl_idle", 16'(IRQ), 16'd0);
    checkReg("lvl_pend", 4'd2, 16'h0000);

    // W1C racing a new edge on ch0
    writeReg(4'd1, 16'h00FF);
    writeReg(4'd0, 16'h0000);
    applyStimulus(8'h01);
    tick(2);
    writeReg(4'd2, 16'h0001);
    checkReg("w1c_race", 4'd2, 16'h0001);
    applyStimulus(8'h00);
    tick(1);
    writeReg(4'd2, 16'h0001);
    checkReg("w1c_clear", 4'd2, 16'h0000);

    // Disable while requesting
    tick(1);
    writeReg(4'd0, 16'h0001);
    applyStimulus(8'h01);
    tick(4);
    checkOutput("dis_req", 16'(IRQ), 16'd1);
    applyStimulus(8'h00);
    writeReg(4'd0, 16'h0000);
    checkOutput("dis_prewrite", 16'(IRQ), 16'd1);
    tick(1);
    checkOutput("dis_drop", 16'(IRQ), 16'd0);
    checkReg("oob_read", 4'd11, 16'h0000);
    checkReg("oob_read15", 4'd15, 16'h0000);

    // Asynchronous reset mid-request
    tick(1);
    writeReg(4'd0, 16'h0001);
    tick(1);
    checkOutput("rst_pre", 16'(IRQ), 16'd1);
    #2 rst = 1'b1;
    #1;
    checkIrq("rst_async", 1'b0, 8'h00, 3'd0);
    checkReg("rst_enable", 4'd0, 16'h0000);
    checkReg("rst_mode", 4'd1, 16'h00FF);
    checkReg("rst_pend", 4'd2, 16'h0000);
    checkReg("rst_pri0", 4'd3, 16'h0000);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Randomised rounds against the pending/priority model
    modelPend = '0;
    for (int r = 0; r < 8; r++) begin
      modelEn = 8'($urandom_range(0, 255));
      writeReg(4'd0, {8'h00, modelEn});
      for (int i = 0; i < 8; i++) begin
        modelPri[i] = $urandom_range(0, 7);
        writeReg(4'(3 + i), 16'(modelPri[i]));
      end
      src = 8'($urandom_range(1, 255));
      applyStimulus(src);
      tick(2);
      applyStimulus(8'h00);
      tick(3);
      modelPend = modelPend | src;
      checkReg("rnd_pend", 4'd2, {8'h00, modelPend});
      for (int k = 0; k < 9; k++) begin
        w = pickWinner();
        if (w < 0) break;
        checkIrq("rnd_win", 1'b1, 8'h80 + 8'(w), 3'(modelPri[w]));
        ackPulse();
        checkOutput("rnd_ack", 16'(IRQ), 16'd0);
        modelPend[w] = 1'b0;
        tick(2);
      end
      checkOutput("rnd_idle", 16'(IRQ), 16'd0);
      checkReg("rnd_left", 4'd2, {8'h00, modelPend});
      tick(1);
      writeReg(4'd2, 16'h00FF);
      modelPend = '0;
      tick(2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
